u_exec_sequencer: RTL and testbench
===================================

Name: u_exec_sequencer

Overview:
- Multi-cycle controller that sequences the U-type execute unit (LUI/AUIPC datapath).
- Owns the program counter and fetches instructions over a req/ack instruction-memory port.
- Decodes each instruction and drives op, 20-bit immediate and PC value into the execute unit.
- Registers the unit's result and pcop, writes the result to the register file, then updates the PC.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned
XLEN, 32, datapath width; only 32 is supported

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
run  input  1  leave IDLE and begin fetching while high
imem_req  output  1  fetch request, held until imem_ack
imem_addr  output  32  fetch address, equals pc
imem_ack  input  1  fetch data valid this cycle
imem_rdata  input  32  fetched instruction
ex_op  output  7  opcode to execute unit
ex_imm  output  20  instr[31:12] to execute unit
ex_pcvalue  output  32  PC of current instruction to execute unit
ex_out  input  32  execute unit result, combinational
ex_pcop  input  2  execute unit PC-update code, combinational
rf_we  output  1  register-file write strobe, one cycle
rf_waddr  output  5  destination register
rf_wdata  output  32  write data
pc  output  32  current program counter
halted  output  1  sequencer in HALT
illegal  output  1  sticky, unsupported opcode or pcop encountered

Behaviour:
- Reset: async assert, forced immediately. Values: state=IDLE, pc=RESET_PC, imem_req=0, rf_we=0, rf_waddr=0, rf_wdata=0, ex_op=0, ex_imm=0, ex_pcvalue=RESET_PC, halted=0, illegal=0.
- IDLE:
  - run=1 -> FETCH next cycle.
  - run=0 -> stay in IDLE.
- FETCH:
  - imem_req=1 and imem_addr=pc from the first FETCH cycle.
  - On imem_ack=1, latch imem_rdata into the instruction register, drop imem_req the next cycle, go to DECODE.
  - imem_ack while not in FETCH is ignored.
- DECODE (1 cycle):
  - ex_op=instr[6:0], ex_imm=instr[31:12], ex_pcvalue=pc. These are registered and held stable through EXEC.
  - Supported opcodes: 7'b0110111 (LUI) and 7'b0010111 (AUIPC).
  - Any other opcode -> illegal=1, go to HALT.
- EXEC (1 cycle): sample ex_out into a result register and ex_pcop into a pcop register.
- WB (1 cycle):
  - rf_we=1, rf_waddr=instr[11:7], rf_wdata=result.
  - If rd=0, rf_we is held 0 (x0 is never written).
  - PC update from the registered pcop:
    - 2'b00 -> pc+4
    - 2'b01 -> result & ~32'h3
    - 2'b10 -> pc unchanged (re-execute)
    - 2'b11 -> illegal=1, go to HALT; the register write still occurs.
  - All PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
  - Next state: run=1 -> FETCH; run=0 -> IDLE.
- HALT: all strobes low, halted=1, stays here until reset; run is ignored.
- Latency: minimum 4 cycles per instruction (FETCH with same-cycle ack, then DECODE, EXEC, WB). Each wait cycle on imem_ack adds one cycle.
- run dropping mid-instruction: the current instruction completes through WB, then the sequencer goes to IDLE.
- Reset mid-FETCH: imem_req drops asynchronously; a late ack is ignored.

Decomposition:
- Shared package/include holds:
  - opcode constants OP_LUI, OP_AUIPC
  - pcop constants PCOP_NEXT, PCOP_JUMP, PCOP_HOLD, PCOP_BAD
  - state encodings ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_WB, ST_HALT
- The execute unit is instantiated externally; the sequencer only drives and samples it.
- No sub-module is required. A small pc_reg sub-module (pc register with next/jump/hold mux) is acceptable.

Test Plan:
- LUI, same-cycle ack: RESET_PC=0, run=1, instr=32'hABCDE0B7 (rd=x1) -> rf_we pulses with rf_waddr=1 and rf_wdata=32'hABCDE000 in the 4th cycle after leaving IDLE; pc then becomes 4.
- AUIPC with wrap: pc=32'h4000_0000, instr imm=20'hC0001, rd=x5, opcode 0010111 -> rf_wdata=32'h0000_1000; pc=32'h4000_0004.
- Delayed ack: imem_ack held low for 3 cycles -> imem_req stays high and imem_addr stays stable throughout; the instruction takes 7 cycles.
- rd=x0 LUI -> rf_we stays 0 for the whole instruction; pc still advances by 4.
- Illegal opcode 7'b0110011 -> illegal=1 and halted=1 after DECODE; no rf_we and no further imem_req even with run=1.
- Reset mid-FETCH: drop rst_n while imem_req=1 -> imem_req=0 immediately, pc=RESET_PC, state=IDLE; a following stray ack causes no effect.

Source files
------------

// File: rtl/u_exec_sequencer_pkg.sv
// Shared constants and state encoding for the U-type execute sequencer.
package u_exec_sequencer_pkg;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [1:0] PCOP_NEXT = 2'b00;
  localparam logic [1:0] PCOP_JUMP = 2'b01;
  localparam logic [1:0] PCOP_HOLD = 2'b10;
  localparam logic [1:0] PCOP_BAD  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_HALT
  } state_e;

  function automatic logic is_supported(input logic [6:0] op);
    return (op == OP_LUI) || (op == OP_AUIPC);
  endfunction

endpackage

// File: rtl/u_exec_sequencer_if.sv
// Instruction-memory, execute-unit and register-file signals of the sequencer.
interface u_exec_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [6:0]  ex_op;
  logic [19:0] ex_imm;
  logic [31:0] ex_pcvalue;
  logic [31:0] ex_out;
  logic [1:0]  ex_pcop;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  modport master (
    output imem_req, imem_addr, ex_op, ex_imm, ex_pcvalue, rf_we, rf_waddr, rf_wdata,
    input  imem_ack, imem_rdata, ex_out, ex_pcop
  );

  modport slave (
    input  imem_req, imem_addr, ex_op, ex_imm, ex_pcvalue, rf_we, rf_waddr, rf_wdata,
    output imem_ack, imem_rdata, ex_out, ex_pcop
  );
endinterface

// File: rtl/u_exec_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB controller for the LUI/AUIPC execute unit.
module u_exec_sequencer
  import u_exec_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned XLEN     = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  u_exec_sequencer_if.master     bus,
  output logic [XLEN-1:0]        pc,
  output logic                   halted,
  output logic                   illegal
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] result_q;
  logic [XLEN-1:0] ex_pcvalue_q;
  logic [6:0]      ex_op_q;
  logic [19:0]     ex_imm_q;
  logic [1:0]      pcop_q;
  logic            illegal_q, illegal_d;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    illegal_d = illegal_q;
    unique case (state_q)
      ST_IDLE:   if (run) state_d = ST_FETCH;
      ST_FETCH:  if (bus.imem_ack) state_d = ST_DECODE;
      ST_DECODE: begin
        if (is_supported(instr_q[6:0])) begin
          state_d = ST_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = ST_HALT;
        end
      end
      ST_EXEC:   state_d = ST_WB;
      ST_WB: begin
        state_d = run ? ST_FETCH : ST_IDLE;
        unique case (pcop_q)
          PCOP_NEXT: pc_d = pc_q + XLEN'(4);
          PCOP_JUMP: pc_d = result_q & ~XLEN'(3);
          PCOP_HOLD: pc_d = pc_q;
          PCOP_BAD: begin
            illegal_d = 1'b1;
            state_d   = ST_HALT;
          end
          default:   pc_d = pc_q;
        endcase
      end
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      result_q     <= '0;
      ex_pcvalue_q <= RESET_PC;
      ex_op_q      <= '0;
      ex_imm_q     <= '0;
      pcop_q       <= PCOP_NEXT;
      illegal_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      illegal_q <= illegal_d;
      if (state_q == ST_FETCH && bus.imem_ack) instr_q <= bus.imem_rdata;
      // Execute-unit operands stay frozen from DECODE until the next DECODE.
      if (state_q == ST_DECODE) begin
        ex_op_q      <= instr_q[6:0];
        ex_imm_q     <= instr_q[31:12];
        ex_pcvalue_q <= pc_q;
      end
      if (state_q == ST_EXEC) begin
        result_q <= bus.ex_out;
        pcop_q   <= bus.ex_pcop;
      end
    end
  end

  assign bus.imem_req   = (state_q == ST_FETCH);
  assign bus.imem_addr  = pc_q;
  assign bus.ex_op      = ex_op_q;
  assign bus.ex_imm     = ex_imm_q;
  assign bus.ex_pcvalue = ex_pcvalue_q;
  // x0 is hardwired to zero, so its write strobe is suppressed.
  assign bus.rf_we      = (state_q == ST_WB) && (instr_q[11:7] != 5'd0);
  assign bus.rf_waddr   = instr_q[11:7];
  assign bus.rf_wdata   = result_q;
  assign pc             = pc_q;
  assign halted         = (state_q == ST_HALT);
  assign illegal        = illegal_q;

endmodule

// File: tb/tb_u_exec_sequencer.sv
// Self-checking bench for u_exec_sequencer with a behavioural LUI/AUIPC execute unit.
module tb_u_exec_sequencer;
  import u_exec_sequencer_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [31:0] pc;
  logic        halted;
  logic        illegal;
  logic [1:0]  pcop_drv;

  u_exec_sequencer_if bus ();

  u_exec_sequencer #(
    .RESET_PC(32'h0000_0000),
    .XLEN    (32)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .bus    (bus),
    .pc     (pc),
    .halted (halted),
    .illegal(illegal)
  );

  // Execute unit stand-in: LUI -> imm<<12, AUIPC -> pc + imm<<12.
  assign bus.ex_out  = (bus.ex_op == OP_LUI) ? {bus.ex_imm, 12'h000}
                                             : bus.ex_pcvalue + {bus.ex_imm, 12'h000};
  assign bus.ex_pcop = pcop_drv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_pc;

  // Serves one fetch and observes the write strobe up to the WB cycle.
  // Cycle 1 is the first FETCH cycle.
  task automatic run_instr(input logic [31:0] instr, input int delay, output int we_cycle,
                           output int we_cnt, output logic [4:0] waddr,
                           output logic [31:0] wdata, output logic addr_ok,
                           output logic timeout);
    int          k;
    int          waits;
    int          ack_k;
    logic        done;
    logic [31:0] addr0;
    we_cycle = -1; we_cnt = 0; waddr = '0; wdata = '0; addr_ok = 1'b1; timeout = 1'b0;
    waits = 0; ack_k = -1; done = 1'b0; k = 0;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      if (bus.imem_req === 1'b1) done = 1'b1;
    end
    if (!done) begin
      timeout = 1'b1;
      return;
    end
    addr0 = bus.imem_addr;
    k     = 1;
    done  = 1'b0;
    while (!done && k < 60) begin
      if (ack_k < 0) begin
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== addr0) addr_ok = 1'b0;
        if (waits < delay) begin
          bus.imem_ack = 1'b0;
          waits++;
        end else begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = instr;
          ack_k          = k;
        end
      end else begin
        bus.imem_ack = 1'b0;
      end
      if (bus.rf_we === 1'b1) begin
        we_cnt++;
        if (we_cycle < 0) we_cycle = k;
        waddr = bus.rf_waddr;
        wdata = bus.rf_wdata;
      end
      if (ack_k >= 0 && k == ack_k + 3) done = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    bus.imem_ack = 1'b0;
    if (!done) timeout = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run   = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    exp_pc = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    run   = 1'b0;
    bus.imem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (pc !== 32'h0 || bus.imem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_pc: got %h/%h, expected 0", pc, bus.imem_addr);
    end
    checks++;
    if (bus.imem_req !== 1'b0 || bus.rf_we !== 1'b0) begin
      errors++; $display("FAIL reset_strobes: req=%b we=%b, expected 0/0", bus.imem_req, bus.rf_we);
    end
    checks++;
    if (bus.ex_op !== 7'h0 || bus.ex_imm !== 20'h0 || bus.ex_pcvalue !== 32'h0 ||
        bus.rf_waddr !== 5'h0 || bus.rf_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_regs: op=%h imm=%h pcv=%h wa=%h wd=%h, expected all 0",
                         bus.ex_op, bus.ex_imm, bus.ex_pcvalue, bus.rf_waddr, bus.rf_wdata);
    end
    checks++;
    if (halted !== 1'b0 || illegal !== 1'b0) begin
      errors++; $display("FAIL reset_flags: halted=%b illegal=%b, expected 0/0", halted, illegal);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.imem_req !== 1'b0) begin
      errors++; $display("FAIL idle_hold: req=%b with run=0, expected 0", bus.imem_req);
    end
    exp_pc = 32'h0;
  endtask

  task automatic test_lui();
    int wc, wn; logic [4:0] wa; logic [31:0] wd; logic ok, to; exp_t e;
    run = 1'b1; pcop_drv = PCOP_NEXT;
    exp_q.push_back('{rd: 5'd1, data: 32'hABCDE000, cyc: 4});
    run_instr(32'hABCDE0B7, 0, wc, wn, wa, wd, ok, to);
    e = exp_q.pop_front();
    checks++;
    if (to || wn !== 1 || wa !== e.rd || wd !== e.data || wc !== e.cyc) begin
      errors++; $display("FAIL lui_write: to=%b n=%0d rd=%0d data=%h cyc=%0d, expected n=1 rd=%0d data=%h cyc=%0d",
                         to, wn, wa, wd, wc, e.rd, e.data, e.cyc);
    end
    exp_pc = exp_pc + 32'd4;
    @(posedge clk); #1;
    checks++;
    if (pc !== exp_pc) begin
      errors++; $display("FAIL lui_pc: got %h, expected %h", pc, exp_pc);
    end
  endtask

  task automatic test_jump_auipc();
    int wc, wn; logic [4:0] wa; logic [31:0] wd; logic ok, to; exp_t e;
    pcop_drv = PCOP_JUMP;
    exp_q.push_back('{rd: 5'd2, data: 32'h4000_0000, cyc: 4});
    run_instr({20'h40000, 5'd2, OP_LUI}, 0, wc, wn, wa, wd, ok, to);
    e = exp_q.pop_front();
    checks++;
    if (to || wn !== 1 || wa !== e.rd || wd !== e.data) begin
      errors++; $display("FAIL jump_write: rd=%0d data=%h n=%0d, expected rd=%0d data=%h",
                         wa, wd, wn, e.rd, e.data);
    end
    exp_pc = e.data & ~32'h3;
    @(posedge clk); #1;
    checks++;
    if (pc !== exp_pc) begin
      errors++; $display("FAIL jump_pc: got %h, expected %h", pc, exp_pc);
    end
    pcop_drv = PCOP_NEXT;
    exp_q.push_back('{rd: 5'd5, data: exp_pc + 32'hC000_1000, cyc: 4});
    run_instr({20'hC0001, 5'd5, OP_AUIPC}, 0, wc, wn, wa, wd, ok, to);
    e = exp_q.pop_front();
    checks++;
    if (to || wn !== 1 || wa !== e.rd || wd !== e.data || wc !== e.cyc) begin
      errors++; $display("FAIL auipc_write: rd=%0d data=%h cyc=%0d, expected rd=%0d data=%h cyc=%0d",
                         wa, wd, wc, e.rd, e.data, e.cyc);
    end
    checks++;
    if (bus.ex_pcvalue !== exp_pc) begin
      errors++; $display("FAIL auipc_pcvalue: got %h, expected %h", bus.ex_pcvalue, exp_pc);
    end
    exp_pc = exp_pc + 32'd4;
    @(posedge clk); #1;
    checks++;
    if (pc !== exp_pc) begin
      errors++; $display("FAIL auipc_pc: got %h, expected %h", pc, exp_pc);
    end
  endtask

  task automatic test_delayed_ack();
    int wc, wn; logic [4:0] wa; logic [31:0] wd; logic ok, to; exp_t e;
    pcop_drv = PCOP_NEXT;
    exp_q.push_back('{rd: 5'd3, data: 32'h1234_5000, cyc: 7});
    run_instr({20'h12345, 5'd3, OP_LUI}, 3, wc, wn, wa, wd, ok, to);
    e = exp_q.pop_front();
    checks++;
    if (to || wn !== 1 || wa !== e.rd || wd !== e.data || wc !== e.cyc) begin
      errors++; $display("FAIL delay_write: rd=%0d data=%h cyc=%0d, expected rd=%0d data=%h cyc=%0d",
                         wa, wd, wc, e.rd, e.data, e.cyc);
    end
    checks++;
    if (ok !== 1'b1) begin
      errors++; $display("FAIL delay_req_stable: stable=%b, expected 1", ok);
    end
    exp_pc = exp_pc + 32'd4;
    @(posedge clk); #1;
    checks++;
    if (pc !== exp_pc) begin
      errors++; $display("FAIL delay_pc: got %h, expected %h", pc, exp_pc);
    end
  endtask

  task automatic test_hold();
    int wc, wn; logic [4:0] wa; logic [31:0] wd; logic ok, to; exp_t e;
    pcop_drv = PCOP_HOLD;
    exp_q.push_back('{rd: 5'd4, data: 32'h0001_0000, cyc: 4});
    run_instr({20'h00010, 5'd4, OP_LUI}, 0, wc, wn, wa, wd, ok, to);
    e = exp_q.pop_front();
    checks++;
    if (to || wn !== 1 || wa !== e.rd || wd !== e.data) begin
      errors++; $display("FAIL hold_write: rd=%0d data=%h, expected rd=%0d data=%h",
                         wa, wd, e.rd, e.data);
    end
    @(posedge clk); #1;
    checks++;
    if (pc !== exp_pc) begin
      errors++; $display("FAIL hold_pc: got %h, expected %h", pc, exp_pc);
    end
    pcop_drv = PCOP_NEXT;
  endtask

  task automatic test_rd0();
    int wc, wn; logic [4:0] wa; logic [31:0] wd; logic ok, to;
    pcop_drv = PCOP_NEXT;
    run_instr({20'hFFFFF, 5'd0, OP_LUI}, 0, wc, wn, wa, wd, ok, to);
    checks++;
    if (to || wn !== 0) begin
      errors++; $display("FAIL rd0_we: to=%b writes=%0d, expected 0", to, wn);
    end
    exp_pc = exp_pc + 32'd4;
    @(posedge clk); #1;
    checks++;
    if (pc !== exp_pc) begin
      errors++; $display("FAIL rd0_pc: got %h, expected %h", pc, exp_pc);
    end
  endtask

  task automatic test_illegal();
    int wc, wn; logic [4:0] wa; logic [31:0] wd; logic ok, to; int reqs;
    run_instr({20'h00001, 5'd6, 7'b0110011}, 0, wc, wn, wa, wd, ok, to);
    checks++;
    if (to || wn !== 0) begin
      errors++; $display("FAIL illegal_we: to=%b writes=%0d, expected 0", to, wn);
    end
    checks++;
    if (illegal !== 1'b1 || halted !== 1'b1) begin
      errors++; $display("FAIL illegal_flags: illegal=%b halted=%b, expected 1/1", illegal, halted);
    end
    reqs = 0;
    run  = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus.imem_req !== 1'b0 || bus.rf_we !== 1'b0) reqs++;
    end
    checks++;
    if (reqs !== 0 || halted !== 1'b1) begin
      errors++; $display("FAIL halt_quiet: active_cycles=%0d halted=%b, expected 0/1", reqs, halted);
    end
  endtask

  task automatic test_pcop_bad();
    int wc, wn; logic [4:0] wa; logic [31:0] wd; logic ok, to; exp_t e;
    do_reset();
    run = 1'b1; pcop_drv = PCOP_BAD;
    exp_q.push_back('{rd: 5'd7, data: 32'h0000_1000, cyc: 4});
    run_instr({20'h00001, 5'd7, OP_LUI}, 0, wc, wn, wa, wd, ok, to);
    e = exp_q.pop_front();
    checks++;
    if (to || wn !== 1 || wa !== e.rd || wd !== e.data || wc !== e.cyc) begin
      errors++; $display("FAIL badpcop_write: rd=%0d data=%h cyc=%0d, expected rd=%0d data=%h cyc=%0d",
                         wa, wd, wc, e.rd, e.data, e.cyc);
    end
    @(posedge clk); #1;
    checks++;
    if (illegal !== 1'b1 || halted !== 1'b1 || pc !== exp_pc) begin
      errors++; $display("FAIL badpcop_halt: illegal=%b halted=%b pc=%h, expected 1/1/%h",
                         illegal, halted, pc, exp_pc);
    end
    pcop_drv = PCOP_NEXT;
  endtask

  task automatic test_reset_mid_fetch();
    logic seen; int bad;
    do_reset();
    run  = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      if (bus.imem_req === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL midfetch_req: req never rose, expected 1");
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.imem_req !== 1'b0 || pc !== 32'h0 || halted !== 1'b0 || illegal !== 1'b0) begin
      errors++; $display("FAIL midfetch_async: req=%b pc=%h halted=%b illegal=%b, expected 0/0/0/0",
                         bus.imem_req, pc, halted, illegal);
    end
    run            = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hABCDE0B7;
    @(negedge clk);
    rst_n = 1'b1;
    bad   = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.imem_req !== 1'b0 || bus.rf_we !== 1'b0) bad++;
    end
    bus.imem_ack = 1'b0;
    checks++;
    if (bad !== 0 || pc !== 32'h0 || bus.ex_op !== 7'h0) begin
      errors++; $display("FAIL stray_ack: active=%0d pc=%h ex_op=%h, expected 0/0/0",
                         bad, pc, bus.ex_op);
    end
  endtask

  initial begin
    pcop_drv       = PCOP_NEXT;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    exp_pc         = 32'h0;
    test_reset();
    test_lui();
    test_jump_auipc();
    test_delayed_ack();
    test_hold();
    test_rd0();
    test_illegal();
    test_pcop_bad();
    test_reset_mid_fetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
